// File: rtl/main_memory_responder_if.sv
// Cache-miss request/response bundle between the cache miss ports and main_memory_responder.
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 512
`endif

interface main_memory_responder_if #(
    parameter int unsigned LINE_W = `DCACHE_LINE_WIDTH,
    parameter int unsigned ADDR_W = 32
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              is_store;
        logic [LINE_W-1:0] data;
    } memory_request_t;

    logic              dc_req_valid;
    memory_request_t   dc_req_info;
    logic              dc_rsp_valid;
    logic [LINE_W-1:0] dc_rsp_data;
    logic              ic_req_valid;
    memory_request_t   ic_req_info;
    logic              ic_rsp_valid;
    logic [LINE_W-1:0] ic_rsp_data;
    logic              mem_busy;

    modport master (
        output dc_req_valid, dc_req_info, ic_req_valid, ic_req_info,
        input  dc_rsp_valid, dc_rsp_data, ic_rsp_valid, ic_rsp_data, mem_busy
    );

    modport slave (
        input  dc_req_valid, dc_req_info, ic_req_valid, ic_req_info,
        output dc_rsp_valid, dc_rsp_data, ic_rsp_valid, ic_rsp_data, mem_busy
    );
endinterface

// File: rtl/main_memory_responder.sv
// Fixed-latency line-wide backing memory serving icache fills and dcache fills/writebacks.
// Optional MEM_ADDR_FAULT_EN adds mem_addr_fault for addresses beyond the array.
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 512
`endif

module main_memory_responder #(
    parameter int unsigned LINE_W      = `DCACHE_LINE_WIDTH,
    parameter int unsigned DEPTH_LINES = 4096,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_LATENCY = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    main_memory_responder_if.slave bus
`ifdef MEM_ADDR_FAULT_EN
    ,
    output logic                   mem_addr_fault
`endif
);
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
    localparam int unsigned CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2,
        TURN    = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              rr_ic;
    logic              lat_dc;
    logic              lat_store;
    logic              lat_fault;
    logic [IDX_W-1:0]  lat_idx;
    logic [LINE_W-1:0] lat_data;
    logic [LINE_W-1:0] mem [DEPTH_LINES];

    logic              grant_dc_c;
    logic [ADDR_W-1:0] req_addr_c;
    logic              req_fault_c;
    logic [LINE_W-1:0] rd_line_c;

    // Single requester wins outright; contention goes to the rr_ptr side
    assign grant_dc_c = bus.dc_req_valid && (!bus.ic_req_valid || !rr_ic);
    assign req_addr_c = grant_dc_c ? bus.dc_req_info.addr : bus.ic_req_info.addr;

`ifdef MEM_ADDR_FAULT_EN
    assign req_fault_c = (req_addr_c >> (OFF_W + IDX_W)) != '0;
`else
    assign req_fault_c = 1'b0;
`endif

    // Store acks echo the latched line; loads read the array as RESPOND is entered
    assign rd_line_c = lat_fault ? '0 : (lat_store ? lat_data : mem[lat_idx]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            rr_ic            <= 1'b0;
            lat_dc           <= 1'b0;
            lat_store        <= 1'b0;
            lat_fault        <= 1'b0;
            lat_idx          <= '0;
            lat_data         <= '0;
            bus.dc_rsp_valid <= 1'b0;
            bus.dc_rsp_data  <= '0;
            bus.ic_rsp_valid <= 1'b0;
            bus.ic_rsp_data  <= '0;
            bus.mem_busy     <= 1'b0;
`ifdef MEM_ADDR_FAULT_EN
            mem_addr_fault   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dc_req_valid || bus.ic_req_valid) begin
                        state        <= WAIT;
                        cnt          <= CNT_W'(MEM_LATENCY - 2);
                        rr_ic        <= grant_dc_c;
                        lat_dc       <= grant_dc_c;
                        lat_store    <= grant_dc_c && bus.dc_req_info.is_store && !req_fault_c;
                        lat_fault    <= req_fault_c;
                        lat_idx      <= req_addr_c[OFF_W +: IDX_W];
                        lat_data     <= bus.dc_req_info.data;
                        bus.mem_busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state            <= RESPOND;
                        bus.dc_rsp_valid <= lat_dc;
                        bus.ic_rsp_valid <= !lat_dc;
                        bus.dc_rsp_data  <= lat_dc ? rd_line_c : '0;
                        bus.ic_rsp_data  <= lat_dc ? '0 : rd_line_c;
`ifdef MEM_ADDR_FAULT_EN
                        mem_addr_fault   <= lat_fault;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESPOND: begin
                    state            <= TURN;
                    bus.dc_rsp_valid <= 1'b0;
                    bus.ic_rsp_valid <= 1'b0;
                    bus.dc_rsp_data  <= '0;
                    bus.ic_rsp_data  <= '0;
`ifdef MEM_ADDR_FAULT_EN
                    mem_addr_fault   <= 1'b0;
`endif
                end
                TURN: begin
                    state        <= IDLE;
                    bus.mem_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Backing array is never reset; the write lands in the RESPOND cycle
    always_ff @(posedge clock) begin
        if (state == RESPOND && lat_store) begin
            mem[lat_idx] <= lat_data;
        end
    end
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed self-checking bench for main_memory_responder (default and MEM_LATENCY=2 instances).
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 512
`endif

module tb_main_memory_responder;
    localparam int unsigned LW = `DCACHE_LINE_WIDTH;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    int              dc_at, ic_at, dc_cnt, ic_cnt, stray, flt_cnt;
    logic            busy_turn, busy_after;
    logic [LW-1:0]   dc_d, ic_d;

    main_memory_responder_if #(.LINE_W(LW), .ADDR_W(32)) b0 ();
    main_memory_responder_if #(.LINE_W(LW), .ADDR_W(32)) b2 ();

`ifdef MEM_ADDR_FAULT_EN
    logic fault0, fault2;
`endif

    main_memory_responder #(.LINE_W(LW), .DEPTH_LINES(4096), .ADDR_W(32), .MEM_LATENCY(10)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (b0)
`ifdef MEM_ADDR_FAULT_EN
        ,
        .mem_addr_fault (fault0)
`endif
    );

    main_memory_responder #(.LINE_W(LW), .DEPTH_LINES(4096), .ADDR_W(32), .MEM_LATENCY(2)) u_dut_l2 (
        .clock          (clock),
        .reset          (reset),
        .bus            (b2)
`ifdef MEM_ADDR_FAULT_EN
        ,
        .mem_addr_fault (fault2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_dc(input logic v, input logic [31:0] a, input logic st, input logic [LW-1:0] d);
        b0.dc_req_valid         = v;
        b0.dc_req_info.addr     = a;
        b0.dc_req_info.is_store = st;
        b0.dc_req_info.data     = d;
    endtask

    task automatic set_ic(input logic v, input logic [31:0] a, input logic st, input logic [LW-1:0] d);
        b0.ic_req_valid         = v;
        b0.ic_req_info.addr     = a;
        b0.ic_req_info.is_store = st;
        b0.ic_req_info.data     = d;
    endtask

    // Watch b0 for n_cyc negedges (n counted from the negedge the request was driven)
    task automatic run(input int n_cyc, input int hold_extra);
        int dc_drop, ic_drop;
        dc_drop = -1; ic_drop = -1;
        dc_at = -1; ic_at = -1; dc_cnt = 0; ic_cnt = 0; stray = 0; flt_cnt = 0;
        busy_turn = 1'b0; busy_after = 1'b1; dc_d = '0; ic_d = '0;
        for (int n = 1; n <= n_cyc; n++) begin
            @(negedge clock);
            if (b0.dc_rsp_valid) begin
                dc_cnt++;
                if (dc_at < 0) begin dc_at = n; dc_d = b0.dc_rsp_data; dc_drop = n + hold_extra; end
            end else if (b0.dc_rsp_data != '0) stray++;
            if (b0.ic_rsp_valid) begin
                ic_cnt++;
                if (ic_at < 0) begin ic_at = n; ic_d = b0.ic_rsp_data; ic_drop = n; end
            end else if (b0.ic_rsp_data != '0) stray++;
`ifdef MEM_ADDR_FAULT_EN
            if (fault0) flt_cnt++;
`endif
            if (dc_at > 0 && n == dc_at + 1) busy_turn = b0.mem_busy;
            if (dc_at > 0 && n == dc_at + 2) busy_after = b0.mem_busy;
            if (n == dc_drop) b0.dc_req_valid = 1'b0;
            if (n == ic_drop) b0.ic_req_valid = 1'b0;
        end
    endtask

    // Single dc request on the MEM_LATENCY=2 instance; returns latency in negedges
    task automatic run2(input logic [31:0] a, input logic st, input logic [LW-1:0] d,
                        output int lat, output logic [LW-1:0] data);
        lat = -1; data = '0;
        b2.dc_req_valid = 1'b1; b2.dc_req_info.addr = a;
        b2.dc_req_info.is_store = st; b2.dc_req_info.data = d;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clock);
            if (b2.dc_rsp_valid && lat < 0) begin
                lat = n; data = b2.dc_rsp_data; b2.dc_req_valid = 1'b0;
            end
        end
        b2.dc_req_valid = 1'b0;
    endtask

    initial begin
        int            lat;
        logic [LW-1:0] d;
        logic [LW-1:0] pat_a5, pat_5a, pat_3c, pat_c3, pat_ff;
        checks = 0; failures = 0;
        pat_a5 = {(LW/8){8'hA5}};
        pat_5a = {(LW/8){8'h5A}};
        pat_3c = {(LW/8){8'h3C}};
        pat_c3 = {(LW/8){8'hC3}};
        pat_ff = {(LW/8){8'hFF}};
        reset = 1'b0;
        set_dc(1'b0, 32'h0, 1'b0, '0);
        set_ic(1'b0, 32'h0, 1'b0, '0);
        b2.dc_req_valid = 1'b0; b2.dc_req_info = '0;
        b2.ic_req_valid = 1'b0; b2.ic_req_info = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", LW'(b0.mem_busy), '0);
        check("rst_dc_valid", LW'(b0.dc_rsp_valid), '0);
        check("rst_ic_valid", LW'(b0.ic_rsp_valid), '0);
        check("rst_dc_data", b0.dc_rsp_data, '0);
        reset = 1'b1;
        @(negedge clock);

        // Contention right after reset: dc store wins, ic fill of the same line follows
        set_dc(1'b1, 32'h40, 1'b1, pat_a5);
        set_ic(1'b1, 32'h40, 1'b0, '0);
        run(30, 0);
        check("arb_dc_lat", LW'(dc_at), LW'(10));
        check("arb_ic_lat", LW'(ic_at), LW'(22));
        check("arb_dc_ack", dc_d, pat_a5);
        check("arb_ic_data", ic_d, pat_a5);
        check("arb_counts", LW'({dc_cnt[7:0], ic_cnt[7:0]}), LW'(16'h0101));
        check("arb_stray", LW'(stray), '0);

        // dc load of stored line; request held one cycle past the response
        set_dc(1'b1, 32'h40, 1'b0, pat_ff);
        run(20, 1);
        check("ld_lat", LW'(dc_at), LW'(10));
        check("ld_data", dc_d, pat_a5);
        check("hold_one_rsp", LW'(dc_cnt), LW'(1));
        check("hold_busy_turn", LW'(busy_turn), LW'(1));
        check("hold_busy_fall", LW'(busy_after), '0);

        // ic with is_store=1 is only a fill; offset bits ignored on the follow-up load
        set_dc(1'b1, 32'h80, 1'b1, pat_5a);
        run(16, 0);
        check("st2_ack", dc_d, pat_5a);
        set_ic(1'b1, 32'h80, 1'b1, pat_ff);
        run(16, 0);
        check("ic_st_fill", ic_d, pat_5a);
        check("ic_st_no_dc", LW'(dc_cnt), '0);
        set_dc(1'b1, 32'hBF, 1'b0, '0);
        run(16, 0);
        check("ic_st_unchanged", dc_d, pat_5a);

        // Reset during WAIT with counter at 5 (grant leaves rr_ptr pointing at ic)
        set_dc(1'b1, 32'h40, 1'b0, '0);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        set_dc(1'b0, 32'h0, 1'b0, '0);
        #1;
        check("mid_rst_busy", LW'(b0.mem_busy), '0);
        check("mid_rst_valid", LW'({b0.dc_rsp_valid, b0.ic_rsp_valid}), '0);
        @(negedge clock);
        reset = 1'b1;
        run(15, 0);
        check("mid_rst_no_rsp", LW'(dc_cnt + ic_cnt), '0);
        set_dc(1'b1, 32'h40, 1'b0, '0);
        set_ic(1'b1, 32'h80, 1'b0, '0);
        run(30, 0);
        check("post_rst_dc_first", LW'(dc_at), LW'(10));
        check("post_rst_ic", LW'(ic_at), LW'(22));
        check("post_rst_dc_data", dc_d, pat_a5);

        // Address one array-size above line 1
        set_dc(1'b1, 32'h40 + 32'(4096 * (LW / 8)), 1'b1, pat_3c);
        run(16, 0);
`ifdef MEM_ADDR_FAULT_EN
        check("alias_fault", LW'(flt_cnt), LW'(1));
        check("alias_data0", dc_d, '0);
        set_dc(1'b1, 32'h40, 1'b0, '0);
        run(16, 0);
        check("alias_line1_kept", dc_d, pat_a5);
`else
        check("alias_ack", dc_d, pat_3c);
        set_dc(1'b1, 32'h40, 1'b0, '0);
        run(16, 0);
        check("alias_line1", dc_d, pat_3c);
`endif

        // MEM_LATENCY=2 instance
        run2(32'h100, 1'b1, pat_c3, lat, d);
        check("l2_st_lat", LW'(lat), LW'(2));
        check("l2_st_ack", d, pat_c3);
        run2(32'h100, 1'b0, '0, lat, d);
        check("l2_ld_lat", LW'(lat), LW'(2));
        check("l2_ld_data", d, pat_c3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
